// File: rtl/mem_line_server_pkg.sv
// rtl/mem_line_server_pkg.sv - shared types and line geometry for the line server
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int BEAT_W         = 2;

endpackage

// File: rtl/mem_line_server_if.sv
// rtl/mem_line_server_if.sv - cache line request/response bundle
interface mem_line_server_if;
  import mem_pkg::*;

  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_data_out;
  logic              mem_r;
  logic              mem_w;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_data;
  logic              mem_err;

  modport master (
    output mem_addr, mem_data_out, mem_r, mem_w,
    input  mem_ready, mem_data, mem_err
  );

  modport slave (
    input  mem_addr, mem_data_out, mem_r, mem_w,
    output mem_ready, mem_data, mem_err
  );

endinterface

// File: rtl/mem_line_server_word_ram.sv
// rtl/mem_line_server_word_ram.sv - single-port word RAM, registered read-first output
module word_ram #(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/mem_line_server.sv
// rtl/mem_line_server.sv - serves 128-bit line reads/writes from a 32-bit word RAM
module mem_line_server
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic               clk,
  input  logic               rst,
  mem_line_server_if.slave   bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        wait_cnt;
  logic [BEAT_W-1:0]       beat;
  logic                    drain;
  logic [IDX_W-1:0]        line_idx;
  logic [LINE_W-1:0]       wr_line;
  logic [3*WORD_W-1:0]     line_buf;
  logic                    op_wr;
  logic                    err_flag;
  logic                    req;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [WORD_W-1:0]       ram_wdata;
  logic [WORD_W-1:0]       ram_rdata;

  logic                    unused_addr;

  assign req         = bus.mem_r | bus.mem_w;
  assign unused_addr = ^{bus.mem_addr[31:ADDR_WIDTH+2], bus.mem_addr[3:0]};

  word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_addr   = {line_idx, beat};
    ram_wdata  = wr_line[beat*WORD_W +: WORD_W];
    case (state)
      IDLE: if (req) state_next = (LATENCY > 0) ? WAIT : XFER;
      WAIT: if (wait_cnt == '0) state_next = XFER;
      XFER: begin
        if (op_wr) begin
          // A reset landing mid-line must not commit the beat in flight.
          ram_we = ~rst;
          if (beat == LAST_BEAT) state_next = DONE;
        end else if (drain) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      beat          <= '0;
      drain         <= 1'b0;
      line_idx      <= '0;
      wr_line       <= '0;
      line_buf      <= '0;
      op_wr         <= 1'b0;
      err_flag      <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.mem_data  <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      case (state)
        IDLE: if (req) begin
          line_idx <= bus.mem_addr[ADDR_WIDTH+1:4];
          wr_line  <= bus.mem_data_out;
          op_wr    <= bus.mem_w;
          err_flag <= bus.mem_r & bus.mem_w;
          wait_cnt <= WAIT_LOAD;
          beat     <= '0;
          drain    <= 1'b0;
        end
        WAIT: wait_cnt <= wait_cnt - 1'b1;
        XFER: begin
          beat <= beat + 1'b1;
          if (!op_wr && beat == LAST_BEAT) drain <= 1'b1;
          // Read data trails its address by one beat; word 3 arrives in the drain cycle.
          if (!op_wr) begin
            case (beat)
              2'd1:    line_buf[WORD_W-1:0]          <= ram_rdata;
              2'd2:    line_buf[2*WORD_W-1:WORD_W]   <= ram_rdata;
              2'd3:    line_buf[3*WORD_W-1:2*WORD_W] <= ram_rdata;
              default: ;
            endcase
          end
          if (state_next == DONE) begin
            bus.mem_ready <= 1'b1;
            bus.mem_err   <= err_flag;
            if (!op_wr) bus.mem_data <= {ram_rdata, line_buf};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_server.sv
// tb/tb_mem_line_server.sv - scoreboard bench for mem_line_server at LATENCY 4 and 0
module tb_mem_line_server;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_line_server_if bus0 ();
  mem_line_server_if bus1 ();

  mem_line_server #(.ADDR_WIDTH(12), .LATENCY(4), .INIT_FILE("")) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  mem_line_server #(.ADDR_WIDTH(12), .LATENCY(0), .INIT_FILE("")) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  typedef struct {
    bit           err;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [127:0] model   [2][1024];
  bit           written [2][1024];
  logic [127:0] last_rd [2];
  int           passed = 0;
  int           total  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic mon(input int sel, input logic err, input logic [127:0] data);
    exp_t e;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      check($sformatf("unexpected_ready%0d", sel), 1, 0);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("ready_cycle%0d", sel), cyc, e.cyc);
      check($sformatf("mem_err%0d", sel), err, e.err);
      check($sformatf("mem_data%0d", sel), data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.mem_ready === 1'b1) mon(0, bus0.mem_err, bus0.mem_data);
    else if (bus0.mem_err === 1'b1) check("err_without_ready0", 1, 0);
    if (bus1.mem_ready === 1'b1) mon(1, bus1.mem_err, bus1.mem_data);
    else if (bus1.mem_err === 1'b1) check("err_without_ready1", 1, 0);
  end

  task automatic set_req(input int sel, input bit r, input bit w,
                         input logic [31:0] a, input logic [127:0] d);
    if (sel == 0) begin
      bus0.mem_r = r; bus0.mem_w = w; bus0.mem_addr = a; bus0.mem_data_out = d;
    end else begin
      bus1.mem_r = r; bus1.mem_w = w; bus1.mem_addr = a; bus1.mem_data_out = d;
    end
  endtask

  function automatic bit ready_of(input int sel);
    return (sel == 0) ? (bus0.mem_ready === 1'b1) : (bus1.mem_ready === 1'b1);
  endfunction

  // b2b: issue in the DONE cycle of the previous transaction so the very next IDLE samples it.
  task automatic txn(input int sel, input bit r, input bit w, input logic [31:0] a,
                     input logic [127:0] d, input bit b2b, input bit drop);
    int   lat  = (sel == 0) ? 4 : 0;
    int   idx  = int'((a >> 4) & 32'h3FF);
    bit   seen = 1'b0;
    exp_t e;
    if (!b2b) @(negedge clk);
    set_req(sel, r, w, a, d);
    e.cyc = b2b ? cyc + 1 : cyc;
    e.err = r & w;
    if (w) begin
      model[sel][idx]   = d;
      written[sel][idx] = 1'b1;
      e.cyc += lat + 5;
      e.data = last_rd[sel];
    end else begin
      e.data       = model[sel][idx];
      last_rd[sel] = e.data;
      e.cyc += lat + 6;
    end
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (drop && !b2b && i == 0) set_req(sel, 1'b0, 1'b0, a, d);
      if (ready_of(sel)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check($sformatf("ready_timeout%0d", sel), 0, 1);
    set_req(sel, 1'b0, 1'b0, a, d);
  endtask

  task automatic random_txns(input int sel, input int n);
    int          idx;
    int          op;
    bit          b2b;
    logic [31:0] a;
    logic [127:0] d;
    for (int k = 0; k < n; k++) begin
      idx = 16 * $urandom_range(1, 6);
      op  = $urandom_range(0, 2);
      if (op == 0 && !written[sel][idx]) op = 1;
      a   = ($urandom() & 32'hFFFF_C00F) | (32'(idx) << 4);
      d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      b2b = ($urandom_range(0, 3) == 0);
      txn(sel, op != 1, op != 0, a, d, b2b, !b2b && ($urandom_range(0, 3) == 0));
    end
  endtask

  logic [127:0] pre_line;
  int           start;

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 128'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 128'h0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready0", bus0.mem_ready, 0);
    check("rst_err0",   bus0.mem_err,   0);
    check("rst_data0",  bus0.mem_data,  0);
    check("rst_ready1", bus1.mem_ready, 0);
    check("rst_data1",  bus1.mem_data,  0);
    rst = 1'b0;

    pre_line = 128'h44444444_33333333_22222222_11111111;
    txn(0, 0, 1, 32'h0000_0100, pre_line, 0, 0);
    txn(0, 1, 0, 32'h0000_0100, 128'h0, 0, 0);
    txn(0, 0, 1, 32'h0000_010C, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0, 0);
    txn(0, 1, 0, 32'h0000_0100, 128'h0, 0, 0);

    txn(0, 0, 1, 32'h0000_0200, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0);
    txn(0, 1, 0, 32'h0000_0200, 128'h0, 1, 0);

    txn(0, 1, 1, 32'h0000_0300, 128'h0BAD0BAD_12345678_9ABCDEF0_CAFECAFE, 0, 0);
    txn(0, 1, 0, 32'h0000_0300, 128'h0, 0, 0);

    txn(0, 0, 1, 32'h0000_0400, {4{32'h55555555}}, 0, 0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, 32'h0000_0400, {4{32'hAAAAAAAA}});
    start = cyc;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", bus0.mem_ready, 0);
    check("abort_err",   bus0.mem_err,   0);
    check("abort_data",  bus0.mem_data,  0);
    check("abort_cycle", cyc - start, 8);
    last_rd[0] = '0;
    last_rd[1] = '0;
    model[0][32'h40] = {32'h55555555, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA};
    repeat (3) @(negedge clk);
    txn(0, 1, 0, 32'h0000_0400, 128'h0, 0, 0);

    random_txns(0, 40);

    txn(1, 0, 1, 32'h0000_0100, 128'h01010101_02020202_03030303_04040404, 0, 1);
    txn(1, 1, 0, 32'hFFFF_C105, 128'h0, 0, 1);
    txn(1, 0, 1, 32'h0000_0200, 128'hF0F0F0F0_0F0F0F0F_12121212_34343434, 0, 0);
    txn(1, 1, 0, 32'h0000_0200, 128'h0, 1, 0);
    txn(1, 1, 1, 32'h0000_0300, 128'h77777777_66666666_55555555_44444444, 0, 0);
    random_txns(1, 20);

    repeat (5) @(negedge clk);
    check("queues_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
